// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter feeding a single registered
// output word with a valid/ready handshake.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req0, D0          requester 0 request and data (D0 held while req0 high)
//   req1, D1          requester 1 request and data (D1 held while req1 high)
//   gnt0, gnt1        one-cycle registered grant pulses
//   Y, S              registered winner data and winner index (0 = D0, 1 = D1)
//   valid, ready      output handshake; transfer on valid && ready
//   cnt0, cnt1        per-requester grant counters, mod 256
//
// Arbitration happens only in IDLE; the captured word is held in HOLD until it
// is accepted, so at most one word leaves every two cycles. Every output is
// driven straight from a register.
module mux_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] D0,
    input  logic             req1,
    input  logic [WIDTH-1:0] D1,
    input  logic             ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] Y,
    output logic             S,
    output logic             valid,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_win;
    logic               r_last;
    logic               r_gnt0;
    logic               r_gnt1;
    logic [WIDTH-1:0]   r_y;
    logic               r_s;
    logic [7:0]         r_cnt0;
    logic [7:0]         r_cnt1;

    // On a tie the requester that did not win last time gets the grant.
    assign w_win = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_next = HOLD;
                    w_load = 1'b1;
                end
            end
            HOLD: begin
                // valid is high throughout HOLD, so ready alone completes it.
                if (ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;  // requester 0 wins the first tie
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_y    <= '0;
            r_s    <= 1'b0;
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else begin
            // Grant pulse coincides with the first HOLD cycle.
            r_gnt0 <= w_load && !w_win;
            r_gnt1 <= w_load &&  w_win;
            if (w_load) begin
                r_y    <= w_win ? D1 : D0;
                r_s    <= w_win;
                r_last <= w_win;
                if (w_win) r_cnt1 <= r_cnt1 + 8'd1;
                else       r_cnt0 <= r_cnt0 + 8'd1;
            end
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign Y     = r_y;
    assign S     = r_s;
    assign valid = (r_state == HOLD);
    assign cnt0  = r_cnt0;
    assign cnt1  = r_cnt1;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and randomized checks of mux_arbiter against a
// transaction-level reference model (one pending word, round-robin on ties).
module tb_mux_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, ready = 1'b0;
    logic [WIDTH-1:0] D0 = '0, D1 = '0;
    logic             gnt0, gnt1, S, valid;
    logic [WIDTH-1:0] Y;
    logic [7:0]       cnt0, cnt1;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    bit        m_busy;
    bit [31:0] m_y;
    bit        m_s;
    int        m_cnt [2];
    int        m_last;
    bit        m_gnt [2];
    bit        prev_valid;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .D0(D0), .req1(req1), .D1(D1), .ready(ready),
        .gnt0(gnt0), .gnt1(gnt1), .Y(Y), .S(S), .valid(valid),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_y = 0; m_s = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_last = 1;
        m_gnt[0] = 0; m_gnt[1] = 0;
    endtask

    task automatic check_all();
        chk("valid", valid, m_busy);
        chk("Y", Y, m_y);
        chk("S", S, m_s);
        chk("gnt0", gnt0, m_gnt[0]);
        chk("gnt1", gnt1, m_gnt[1]);
        chk("cnt0", cnt0, m_cnt[0] % 256);
        chk("cnt1", cnt1, m_cnt[1] % 256);
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("gnt_rise", (gnt0 | gnt1) & ~(valid & ~prev_valid), 0);
    endtask

    // One clock: sample the inputs the edge sees, advance the model, compare.
    task automatic step();
        bit r[2];
        bit [31:0] d[2];
        bit rdy;
        int w;
        r[0] = req0; r[1] = req1; d[0] = D0; d[1] = D1; rdy = ready;
        prev_valid = valid;
        @(posedge clk);
        #1;
        m_gnt[0] = 0; m_gnt[1] = 0;
        if (m_busy) begin
            if (rdy) m_busy = 0;
        end else if (r[0] || r[1]) begin
            if (r[0] && r[1]) w = 1 - m_last;
            else              w = r[1] ? 1 : 0;
            m_busy = 1;
            m_y = d[w];
            m_s = w[0];
            m_cnt[w]++;
            m_last = w;
            m_gnt[w] = 1;
        end
        check_all();
    endtask

    initial begin
        model_reset();
        prev_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();                                   // reset state
        reset = 1'b0;

        // single request from requester 0
        req0 = 1; D0 = 32'hAAAA5555;
        step();
        req0 = 0; ready = 1;
        step();
        step();

        // both held, ready high: alternate 0x1 / 0x2 every other cycle
        req0 = 1; req1 = 1; D0 = 32'h1; D1 = 32'h2; ready = 1;
        repeat (8) step();

        // stall in HOLD while req1 toggles
        req0 = 0; req1 = 0; ready = 0;
        step();                                        // IDLE if previous word consumed
        req0 = 1; D0 = 32'h1234_5678;
        if (!valid) step();
        req0 = 0;
        for (int i = 0; i < 5; i++) begin
            req1 = ~req1; D1 = $urandom;
            step();
        end
        req1 = 0; ready = 1;
        step();
        step();

        // reset asserted between edges while holding a word
        req0 = 1; ready = 0;
        step();
        if (!valid) step();
        #2 reset = 1;
        #1;
        model_reset();
        prev_valid = 0;
        chk("rst_valid", valid, 0);
        chk("rst_Y", Y, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        #1 reset = 0;
        req0 = 1; req1 = 1; D0 = 32'hC0DE_0000; D1 = 32'hC0DE_0001;
        step();                                        // tie -> requester 0
        chk("tie_after_reset_S", S, 0);
        req0 = 0; req1 = 0; ready = 1;
        step();

        // 256 grants to requester 0: counter wraps
        reset = 1; #1; model_reset(); prev_valid = 0; #1 reset = 0;
        req0 = 1; req1 = 0; ready = 1;
        repeat (512) step();
        chk("wrap_cnt0", cnt0, 0);
        chk("wrap_cnt1", cnt1, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            req0 = $urandom_range(0, 1);
            req1 = $urandom_range(0, 1);
            ready = ($urandom_range(0, 3) != 0);
            D0 = $urandom;
            D1 = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data-path width of D0, D1 and Y.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port req0  input  1  SHALL be requester 0 request; D0 must be held stable while req0 is high.
REQ-005 Port D0  input  WIDTH  SHALL be requester 0 data.
REQ-006 Port req1  input  1  SHALL be requester 1 request; D1 must be held stable while req1 is high.
REQ-007 Port D1  input  WIDTH  SHALL be requester 1 data.
REQ-008 Port gnt0  output  1  SHALL be a one-cycle registered grant pulse to requester 0.
REQ-009 Port gnt1  output  1  SHALL be a one-cycle registered grant pulse to requester 1.
REQ-010 Port Y  output  WIDTH  SHALL be the registered data of the most recent winner.
REQ-011 Port S  output  1  SHALL be the registered mux select of the most recent winner (0 = D0, 1 = D1).
REQ-012 Port valid  output  1  SHALL be high while Y holds an unconsumed word.
REQ-013 Port ready  input  1  SHALL be the consumer accept signal; a transfer occurs on a cycle with valid && ready.
REQ-014 Port cnt0  output  8  SHALL be the number of grants issued to requester 0, mod 256.
REQ-015 Port cnt1  output  8  SHALL be the number of grants issued to requester 1, mod 256.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-017 In IDLE with neither req0 nor req1 high, the block SHALL stay in IDLE with Y, S and counters unchanged.
REQ-018 In IDLE with exactly one request high, that requester SHALL win.
REQ-019 In IDLE with both requests high, the winner SHALL be the requester not granted most recently (round-robin, tracked by a last-winner register).
REQ-020 On the edge leaving IDLE with a winner, Y SHALL load the winner's data, S SHALL load the winner index, the winner's count SHALL increment, and state SHALL go to HOLD.
REQ-021 On that same edge, the winner's gnt SHALL be set for exactly the following cycle, so gnt and the rising valid appear together one cycle after capture.
REQ-022 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-023 valid SHALL equal (state == HOLD).
REQ-024 In HOLD, Y and S SHALL stay stable and requests SHALL be ignored until valid && ready.
REQ-025 On valid && ready, state SHALL return to IDLE, with valid low the next cycle.
REQ-026 Arbitration SHALL resume on the IDLE cycle that follows; sustained throughput is at most one word per two cycles.
REQ-027 A request still pending after its grant SHALL be treated as a new request.
REQ-028 Requests that drop before winning SHALL be discarded without side effects.
REQ-029 Counters SHALL wrap from 255 to 0 with no flag.
REQ-030 The block SHALL hold no combinational path from req*/D*/ready to any output.

Reset
REQ-031 While reset is high, regardless of clk, the block SHALL force: state IDLE, valid 0, gnt0 0, gnt1 0, Y 0, S 0, cnt0 0, cnt1 0, and last-winner 1 (so requester 0 wins the first tie).
REQ-032 Reset asserted in HOLD SHALL drop valid immediately, and the held word SHALL be lost.
REQ-033 After reset deasserts, the first arbitration SHALL take place on the first rising edge with reset low.

Verification
REQ-034 Reset, then req0=1, D0=0xAAAA5555 for one edge -> next cycle gnt0=1, valid=1, Y=0xAAAA5555, S=0, cnt0=1.
REQ-035 Both requests held (D0=0x1, D1=0x2), ready=1 continuously -> Y sequence 0x1, 0x2, 0x1, 0x2; gnt alternates; a valid word appears every other cycle.
REQ-036 Winner in HOLD with ready=0 for 5 cycles while req1 toggles -> Y, S and valid stable; no gnt issued; a transfer occurs on the first cycle ready=1.
REQ-037 req0 held for 256 grants with ready=1 -> cnt0 wraps to 0; cnt1 stays 0.
REQ-038 Reset pulsed mid-HOLD (between edges) -> valid, Y and counters go to 0 before the next edge; next tie is won by requester 0.
REQ-039 Every cycle of every test -> never gnt0 && gnt1, and never gnt without a valid rising edge that same cycle.
